// File: rtl/hemaia_sb_pkg.sv
// Shared definitions for the HeMAiA superbank arbiter: arbitration mode,
// response-tag builder and parameter sanity helpers.
`define HEMAIA_SB_RSP_TAG_T(name, idx_w, nb) \
  typedef struct packed { \
    logic                 wide_vld; \
    logic [(idx_w)-1:0]   wide_idx; \
    logic [(nb)-1:0]      narrow_rd; \
  } name;

package hemaia_sb_pkg;

  typedef enum logic {
    WIDE_PRIO = 1'b0,
    FAIR      = 1'b1
  } arb_mode_e;

  localparam int unsigned MinMemLatency = 32'd1;
  localparam int unsigned MaxMemLatency = 32'd3;

  function automatic bit mem_latency_ok(input int unsigned lat);
    return (lat >= MinMemLatency) && (lat <= MaxMemLatency);
  endfunction

  function automatic bit starve_limit_ok(input int unsigned lim);
    return lim >= 32'd1;
  endfunction

  // A single requester still needs a 1-bit index field in the tag.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/hemaia_sb_rsp_pipe.sv
// Fixed-depth shift register carrying read-response tags alongside the bank
// read latency; cleared by synchronous reset so in-flight reads are dropped.
module hemaia_sb_rsp_pipe #(
  parameter int unsigned Depth = 32'd1,
  parameter int unsigned Width = 32'd1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] tag_i,
  output logic [Width-1:0] tag_o
);

  logic [Width-1:0] stage_q [Depth];

  // Tag shift register, one stage per cycle of bank latency
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/hemaia_superbank_arbiter.sv
// Arbitrates one superbank between wide requesters (all banks at once) and
// per-bank narrow requesters; routes read data back through a tag pipe.
module hemaia_superbank_arbiter
  import hemaia_sb_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = 32'd64,
  parameter int unsigned WideDataWidth   = 32'd512,
  parameter int unsigned NumWideInp      = 32'd2,
  parameter int unsigned AddrWidth       = 32'd10,
  parameter int unsigned StarveLimit     = 32'd4,
  parameter int unsigned MemLatency      = 32'd1,
  localparam int unsigned NB             = WideDataWidth / NarrowDataWidth,
  localparam int unsigned NarrowStrbW    = NarrowDataWidth / 32'd8,
  localparam int unsigned WideStrbW      = WideDataWidth / 32'd8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            mode_i,
  input  logic [NumWideInp-1:0]           wide_q_valid_i,
  output logic [NumWideInp-1:0]           wide_q_ready_o,
  input  logic [NumWideInp*AddrWidth-1:0] wide_q_addr_i,
  input  logic [NumWideInp-1:0]           wide_q_write_i,
  input  logic [NumWideInp*WideDataWidth-1:0] wide_q_data_i,
  input  logic [NumWideInp*WideStrbW-1:0] wide_q_strb_i,
  output logic [NumWideInp-1:0]           wide_p_valid_o,
  output logic [WideDataWidth-1:0]        wide_p_data_o,
  input  logic [NB-1:0]                   narrow_q_valid_i,
  output logic [NB-1:0]                   narrow_q_ready_o,
  input  logic [NB*AddrWidth-1:0]         narrow_q_addr_i,
  input  logic [NB-1:0]                   narrow_q_write_i,
  input  logic [NB*NarrowDataWidth-1:0]   narrow_q_data_i,
  input  logic [NB*NarrowStrbW-1:0]       narrow_q_strb_i,
  output logic [NB-1:0]                   narrow_p_valid_o,
  output logic [NB*NarrowDataWidth-1:0]   narrow_p_data_o,
  output logic [NB-1:0]                   bank_cs_o,
  output logic [NB-1:0]                   bank_we_o,
  output logic [NB*AddrWidth-1:0]         bank_addr_o,
  output logic [NB*NarrowStrbW-1:0]       bank_be_o,
  output logic [NB*NarrowDataWidth-1:0]   bank_wdata_o,
  input  logic [NB*NarrowDataWidth-1:0]   bank_rdata_i
);

  localparam int unsigned WIdxW   = idx_width(NumWideInp);
  localparam int unsigned StarveW = $clog2(StarveLimit + 32'd1);
  localparam int unsigned TagW    = 32'd1 + WIdxW + NB;

  if ((WideDataWidth % NarrowDataWidth) != 0) begin : g_err_width
    $error("WideDataWidth must be a multiple of NarrowDataWidth");
  end
  if (NB < 32'd2) begin : g_err_nb
    $error("superbank needs at least two banks");
  end
  if (!mem_latency_ok(MemLatency)) begin : g_err_lat
    $error("MemLatency must be within 1..3");
  end
  if (!starve_limit_ok(StarveLimit)) begin : g_err_starve
    $error("StarveLimit must be at least 1");
  end

  `HEMAIA_SB_RSP_TAG_T(rsp_tag_t, WIdxW, NB)

  arb_mode_e              mode_q;
  logic [WIdxW-1:0]       rr_q, rr_d;
  logic [StarveW-1:0]     starve_q, starve_d;

  logic [NumWideInp-1:0]  rr_mask_s;
  logic [WIdxW-1:0]       wide_pick_s;
  logic                   wide_found_s;
  logic                   sel_write_s;
  logic [AddrWidth-1:0]   sel_addr_s;
  logic [WideDataWidth-1:0] sel_data_s;
  logic [WideStrbW-1:0]   sel_strb_s;
  logic                   starve_force_s;
  logic                   wide_gnt_s;
  logic [NumWideInp-1:0]  wide_gnt_vec_s;
  logic [NB-1:0]          narrow_gnt_s;
  rsp_tag_t               tag_in_s, tag_out_s;
  logic [TagW-1:0]        tag_out_vec_s;

  // Round-robin pick: lowest valid index at or above rr_q, else lowest valid
  always_comb begin
    logic [WIdxW-1:0] lo_all;
    logic [WIdxW-1:0] lo_msk;
    lo_all = '0;
    lo_msk = '0;
    for (int unsigned i = 0; i < NumWideInp; i++) begin
      rr_mask_s[i] = wide_q_valid_i[i] && (WIdxW'(i) >= rr_q);
    end
    for (int i = int'(NumWideInp) - 1; i >= 0; i--) begin
      lo_all = wide_q_valid_i[i] ? WIdxW'(i) : lo_all;
      lo_msk = rr_mask_s[i] ? WIdxW'(i) : lo_msk;
    end
    wide_found_s = |wide_q_valid_i;
    wide_pick_s  = (|rr_mask_s) ? lo_msk : lo_all;
  end

  // Payload mux of the picked wide requester
  always_comb begin
    logic match;
    match       = 1'b0;
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_data_s  = '0;
    sel_strb_s  = '0;
    for (int unsigned i = 0; i < NumWideInp; i++) begin
      match        = (wide_pick_s == WIdxW'(i));
      sel_write_s |= match & wide_q_write_i[i];
      sel_addr_s  |= {AddrWidth{match}} & wide_q_addr_i[i*AddrWidth +: AddrWidth];
      sel_data_s  |= {WideDataWidth{match}} & wide_q_data_i[i*WideDataWidth +: WideDataWidth];
      sel_strb_s  |= {WideStrbW{match}} & wide_q_strb_i[i*WideStrbW +: WideStrbW];
    end
  end

  // Grant decision; the fair-mode limit hands one cycle to the narrow side
  always_comb begin
    starve_force_s = (mode_q == FAIR) && (starve_q == StarveW'(StarveLimit));
    wide_gnt_s     = rst_ni && wide_found_s && !starve_force_s;
    narrow_gnt_s   = (rst_ni && !wide_gnt_s) ? narrow_q_valid_i : '0;
    for (int unsigned i = 0; i < NumWideInp; i++) begin
      wide_gnt_vec_s[i] = wide_gnt_s && (wide_pick_s == WIdxW'(i));
    end
  end

  assign wide_q_ready_o   = wide_gnt_vec_s;
  assign narrow_q_ready_o = narrow_gnt_s;

  // Bank port drive; idle banks are held at zero
  always_comb begin
    bank_cs_o    = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wide_gnt_s) begin
        bank_cs_o[b] = 1'b1;
        bank_we_o[b] = sel_write_s;
        bank_addr_o[b*AddrWidth +: AddrWidth] = sel_addr_s;
        bank_be_o[b*NarrowStrbW +: NarrowStrbW] = sel_strb_s[b*NarrowStrbW +: NarrowStrbW];
        bank_wdata_o[b*NarrowDataWidth +: NarrowDataWidth] =
          sel_data_s[b*NarrowDataWidth +: NarrowDataWidth];
      end else if (narrow_gnt_s[b]) begin
        bank_cs_o[b] = 1'b1;
        bank_we_o[b] = narrow_q_write_i[b];
        bank_addr_o[b*AddrWidth +: AddrWidth] = narrow_q_addr_i[b*AddrWidth +: AddrWidth];
        bank_be_o[b*NarrowStrbW +: NarrowStrbW] = narrow_q_strb_i[b*NarrowStrbW +: NarrowStrbW];
        bank_wdata_o[b*NarrowDataWidth +: NarrowDataWidth] =
          narrow_q_data_i[b*NarrowDataWidth +: NarrowDataWidth];
      end else begin
        bank_cs_o[b] = 1'b0;
      end
    end
  end

  // Next-state for round-robin pointer and starvation counter
  always_comb begin
    rr_d     = rr_q;
    starve_d = '0;
    if (wide_gnt_s) begin
      rr_d = (wide_pick_s == WIdxW'(NumWideInp - 32'd1)) ? '0 : wide_pick_s + WIdxW'(1);
    end else begin
      rr_d = rr_q;
    end
    if (arb_mode_e'(mode_i) != mode_q) begin
      starve_d = '0;
    end else if ((mode_q == FAIR) && wide_gnt_s && (|narrow_q_valid_i)) begin
      starve_d = starve_q + StarveW'(1);
    end else begin
      starve_d = '0;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q   <= WIDE_PRIO;
      rr_q     <= '0;
      starve_q <= '0;
    end else begin
      mode_q   <= arb_mode_e'(mode_i);
      rr_q     <= rr_d;
      starve_q <= starve_d;
    end
  end

  // Tag for the read issued this cycle (writes produce no response)
  always_comb begin
    tag_in_s.wide_vld  = wide_gnt_s & ~sel_write_s;
    tag_in_s.wide_idx  = wide_pick_s;
    tag_in_s.narrow_rd = narrow_gnt_s & ~narrow_q_write_i;
  end

  hemaia_sb_rsp_pipe #(
    .Depth (MemLatency),
    .Width (TagW)
  ) i_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (tag_in_s),
    .tag_o  (tag_out_vec_s)
  );

  assign tag_out_s = rsp_tag_t'(tag_out_vec_s);

  // Response valid decode from the retiring tag
  always_comb begin
    wide_p_valid_o = '0;
    for (int unsigned i = 0; i < NumWideInp; i++) begin
      wide_p_valid_o[i] = tag_out_s.wide_vld && (tag_out_s.wide_idx == WIdxW'(i));
    end
  end

  assign narrow_p_valid_o = tag_out_s.narrow_rd;
  assign wide_p_data_o    = bank_rdata_i;
  assign narrow_p_data_o  = bank_rdata_i;

endmodule

// File: tb/tb_hemaia_superbank_arbiter.sv
// Directed bench for hemaia_superbank_arbiter with a behavioural SRAM model
// of MemLatency read latency behind the bank ports.
module tb_hemaia_superbank_arbiter;

  localparam int NDW = 64;
  localparam int WDW = 512;
  localparam int NW  = 2;
  localparam int AW  = 10;
  localparam int SL  = 4;
  localparam int LAT = 3;
  localparam int NB  = WDW / NDW;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic mode_i;
  logic [NW-1:0]       wide_q_valid_i, wide_q_ready_o, wide_q_write_i, wide_p_valid_o;
  logic [NW*AW-1:0]    wide_q_addr_i;
  logic [NW*WDW-1:0]   wide_q_data_i;
  logic [NW*WDW/8-1:0] wide_q_strb_i;
  logic [WDW-1:0]      wide_p_data_o;
  logic [NB-1:0]       narrow_q_valid_i, narrow_q_ready_o, narrow_q_write_i, narrow_p_valid_o;
  logic [NB*AW-1:0]    narrow_q_addr_i;
  logic [NB*NDW-1:0]   narrow_q_data_i, narrow_p_data_o;
  logic [NB*NDW/8-1:0] narrow_q_strb_i;
  logic [NB-1:0]       bank_cs_o, bank_we_o;
  logic [NB*AW-1:0]    bank_addr_o;
  logic [NB*NDW/8-1:0] bank_be_o;
  logic [NB*NDW-1:0]   bank_wdata_o, bank_rdata_i;

  logic            pl_en;
  int              pl_bank;
  logic [AW-1:0]   pl_addr;
  logic [NDW-1:0]  pl_data;

  logic [NDW-1:0] mem [NB][1<<AW];
  logic [NDW-1:0] rd_pipe [NB][LAT];

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hemaia_superbank_arbiter #(
    .NarrowDataWidth (NDW),
    .WideDataWidth   (WDW),
    .NumWideInp      (NW),
    .AddrWidth       (AW),
    .StarveLimit     (SL),
    .MemLatency      (LAT)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .mode_i           (mode_i),
    .wide_q_valid_i   (wide_q_valid_i),
    .wide_q_ready_o   (wide_q_ready_o),
    .wide_q_addr_i    (wide_q_addr_i),
    .wide_q_write_i   (wide_q_write_i),
    .wide_q_data_i    (wide_q_data_i),
    .wide_q_strb_i    (wide_q_strb_i),
    .wide_p_valid_o   (wide_p_valid_o),
    .wide_p_data_o    (wide_p_data_o),
    .narrow_q_valid_i (narrow_q_valid_i),
    .narrow_q_ready_o (narrow_q_ready_o),
    .narrow_q_addr_i  (narrow_q_addr_i),
    .narrow_q_write_i (narrow_q_write_i),
    .narrow_q_data_i  (narrow_q_data_i),
    .narrow_q_strb_i  (narrow_q_strb_i),
    .narrow_p_valid_o (narrow_p_valid_o),
    .narrow_p_data_o  (narrow_p_data_o),
    .bank_cs_o        (bank_cs_o),
    .bank_we_o        (bank_we_o),
    .bank_addr_o      (bank_addr_o),
    .bank_be_o        (bank_be_o),
    .bank_wdata_o     (bank_wdata_o),
    .bank_rdata_i     (bank_rdata_i)
  );

  // SRAM model: byte-enabled writes, LAT-cycle read pipe, bench preload port
  always @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      for (int k = LAT - 1; k > 0; k--) rd_pipe[b][k] <= rd_pipe[b][k-1];
      if (bank_cs_o[b]) begin
        if (bank_we_o[b]) begin
          for (int j = 0; j < NDW / 8; j++)
            if (bank_be_o[b*(NDW/8)+j])
              mem[b][bank_addr_o[b*AW +: AW]][j*8 +: 8] <= bank_wdata_o[b*NDW + j*8 +: 8];
        end else begin
          rd_pipe[b][0] <= mem[b][bank_addr_o[b*AW +: AW]];
        end
      end
    end
    if (pl_en) mem[pl_bank][pl_addr] <= pl_data;
  end

  for (genvar g = 0; g < NB; g++) begin : g_rd
    assign bank_rdata_i[g*NDW +: NDW] = rd_pipe[g][LAT-1];
  end

  task automatic idle_inputs;
    wide_q_valid_i   = '0;
    wide_q_write_i   = '0;
    wide_q_addr_i    = '0;
    wide_q_data_i    = '0;
    wide_q_strb_i    = '0;
    narrow_q_valid_i = '0;
    narrow_q_write_i = '0;
    narrow_q_addr_i  = '0;
    narrow_q_data_i  = '0;
    narrow_q_strb_i  = '0;
  endtask

  task automatic preload(input int b, input logic [AW-1:0] a, input logic [NDW-1:0] d);
    @(negedge clk_i);
    pl_en = 1'b1; pl_bank = b; pl_addr = a; pl_data = d;
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    wide_q_valid_i   = '1;
    narrow_q_valid_i = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i); #1;
      checks++; if (wide_q_ready_o !== 2'b00) begin errors++; $display("FAIL reset_wide_ready: got %b expected 00", wide_q_ready_o); end
      checks++; if (narrow_q_ready_o !== 8'h00) begin errors++; $display("FAIL reset_narrow_ready: got %h expected 00", narrow_q_ready_o); end
      checks++; if (bank_cs_o !== 8'h00) begin errors++; $display("FAIL reset_cs: got %h expected 00", bank_cs_o); end
      checks++; if ({wide_p_valid_o, narrow_p_valid_o} !== 10'h000) begin errors++; $display("FAIL reset_p_valid: got %h expected 000", {wide_p_valid_o, narrow_p_valid_o}); end
    end
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read;
    preload(3, 10'h010, 64'hDEAD);
    @(negedge clk_i);
    narrow_q_valid_i[3] = 1'b1;
    narrow_q_addr_i[3*AW +: AW] = 10'h010;
    #1;
    checks++; if (narrow_q_ready_o !== 8'h08) begin errors++; $display("FAIL single_ready: got %h expected 08", narrow_q_ready_o); end
    checks++; if (bank_cs_o !== 8'h08 || bank_we_o !== 8'h00) begin errors++; $display("FAIL single_cs_we: got %h/%h expected 08/00", bank_cs_o, bank_we_o); end
    checks++; if (bank_addr_o[3*AW +: AW] !== 10'h010) begin errors++; $display("FAIL single_addr: got %h expected 010", bank_addr_o[3*AW +: AW]); end
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk_i);
      idle_inputs();
      #1;
      checks++;
      if (narrow_p_valid_o !== ((k == LAT) ? 8'h08 : 8'h00)) begin
        errors++; $display("FAIL single_p_valid cycle %0d: got %h expected %h", k, narrow_p_valid_o, (k == LAT) ? 8'h08 : 8'h00);
      end
      if (k == LAT) begin
        checks++; if (narrow_p_data_o[3*NDW +: NDW] !== 64'hDEAD) begin errors++; $display("FAIL single_p_data: got %h expected dead", narrow_p_data_o[3*NDW +: NDW]); end
      end
    end
  endtask

  task automatic test_wide_alternate;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      wide_q_valid_i   = 2'b11;
      wide_q_write_i   = 2'b11;
      narrow_q_valid_i = '1;
      narrow_q_write_i = '1;
      #1;
      checks++; if (wide_q_ready_o !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_wide_ready cycle %0d: got %b expected %b", c, wide_q_ready_o, (c % 2 == 0) ? 2'b01 : 2'b10); end
      checks++; if (narrow_q_ready_o !== 8'h00) begin errors++; $display("FAIL alt_narrow_ready cycle %0d: got %h expected 00", c, narrow_q_ready_o); end
      checks++; if (bank_cs_o !== 8'hFF) begin errors++; $display("FAIL alt_cs cycle %0d: got %h expected ff", c, bank_cs_o); end
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_fair_starve;
    @(negedge clk_i);
    idle_inputs();
    mode_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      wide_q_valid_i      = 2'b01;
      wide_q_write_i      = 2'b01;
      narrow_q_valid_i[0] = 1'b1;
      narrow_q_write_i[0] = 1'b1;
      #1;
      checks++; if (wide_q_ready_o !== ((c % 5 == 4) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL fair_wide_ready cycle %0d: got %b expected %b", c, wide_q_ready_o, (c % 5 == 4) ? 2'b00 : 2'b01); end
      checks++; if (narrow_q_ready_o !== ((c % 5 == 4) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL fair_narrow_ready cycle %0d: got %h expected %h", c, narrow_q_ready_o, (c % 5 == 4) ? 8'h01 : 8'h00); end
    end
    @(negedge clk_i);
    idle_inputs();
    mode_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_wide_write_read;
    logic [WDW-1:0]   pat;
    logic [NB*AW-1:0] exp_addr;
    for (int b = 0; b < NB; b++) begin
      pat[b*NDW +: NDW]    = {32'hC0DE_0000 + 32'(b), 32'hFACE_0000 + 32'(b)};
      exp_addr[b*AW +: AW] = 10'h020;
    end
    @(negedge clk_i);
    wide_q_valid_i = 2'b10;
    wide_q_write_i = 2'b10;
    wide_q_addr_i[AW +: AW]   = 10'h020;
    wide_q_data_i[WDW +: WDW] = pat;
    wide_q_strb_i[WDW/8 +: WDW/8] = '1;
    #1;
    checks++; if (wide_q_ready_o !== 2'b10) begin errors++; $display("FAIL wwr_write_ready: got %b expected 10", wide_q_ready_o); end
    checks++; if (bank_cs_o !== 8'hFF || bank_we_o !== 8'hFF) begin errors++; $display("FAIL wwr_cs_we: got %h/%h expected ff/ff", bank_cs_o, bank_we_o); end
    checks++; if (bank_be_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wwr_be: got %h expected all ones", bank_be_o); end
    checks++; if (bank_wdata_o !== pat) begin errors++; $display("FAIL wwr_wdata: got %h expected %h", bank_wdata_o, pat); end
    checks++; if (bank_addr_o !== exp_addr) begin errors++; $display("FAIL wwr_addr: got %h expected %h", bank_addr_o, exp_addr); end
    @(negedge clk_i);
    wide_q_write_i = 2'b00;
    wide_q_strb_i  = '0;
    #1;
    checks++; if (wide_q_ready_o !== 2'b10 || bank_we_o !== 8'h00) begin errors++; $display("FAIL wwr_read_issue: got %b/%h expected 10/00", wide_q_ready_o, bank_we_o); end
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk_i);
      idle_inputs();
      #1;
      checks++;
      if (wide_p_valid_o !== ((k == LAT) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL wwr_p_valid cycle %0d: got %b expected %b", k, wide_p_valid_o, (k == LAT) ? 2'b10 : 2'b00);
      end
      if (k == LAT) begin
        checks++; if (wide_p_data_o !== pat) begin errors++; $display("FAIL wwr_p_data: got %h expected %h", wide_p_data_o, pat); end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) preload(1, AW'(i), 64'h1000 + 64'(i));
    for (int c = 0; c < 8 + LAT + 1; c++) begin
      @(negedge clk_i);
      idle_inputs();
      if (c < 8) begin
        narrow_q_valid_i[1] = 1'b1;
        narrow_q_addr_i[AW +: AW] = AW'(c);
      end
      #1;
      if (c < 8) begin
        checks++; if (narrow_q_ready_o !== 8'h02) begin errors++; $display("FAIL b2b_ready cycle %0d: got %h expected 02", c, narrow_q_ready_o); end
      end
      checks++;
      if (narrow_p_valid_o !== ((c >= LAT && c < 8 + LAT) ? 8'h02 : 8'h00)) begin
        errors++; $display("FAIL b2b_p_valid cycle %0d: got %h expected %h", c, narrow_p_valid_o, (c >= LAT && c < 8 + LAT) ? 8'h02 : 8'h00);
      end
      if (c >= LAT && c < 8 + LAT) begin
        checks++;
        if (narrow_p_data_o[NDW +: NDW] !== 64'h1000 + 64'(c - LAT)) begin
          errors++; $display("FAIL b2b_p_data cycle %0d: got %h expected %h", c, narrow_p_data_o[NDW +: NDW], 64'h1000 + 64'(c - LAT));
        end
      end
    end
  endtask

  task automatic test_reset_inflight;
    @(negedge clk_i);
    idle_inputs();
    wide_q_valid_i = 2'b01;
    wide_q_write_i = 2'b01;
    #1;
    checks++; if (wide_q_ready_o !== 2'b01) begin errors++; $display("FAIL rif_pre_grant: got %b expected 01", wide_q_ready_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      idle_inputs();
      narrow_q_valid_i[2] = 1'b1;
      narrow_q_addr_i[2*AW +: AW] = AW'(i);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++; if (narrow_q_ready_o !== 8'h00 || bank_cs_o !== 8'h00) begin errors++; $display("FAIL rif_in_reset: got %h/%h expected 00/00", narrow_q_ready_o, bank_cs_o); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      idle_inputs();
      rst_ni = (c == 0) ? 1'b0 : 1'b1;
      if (c == 1 || c == 2) begin
        wide_q_valid_i = 2'b11;
        wide_q_write_i = 2'b11;
      end
      #1;
      checks++; if ({wide_p_valid_o, narrow_p_valid_o} !== 10'h000) begin errors++; $display("FAIL rif_p_valid cycle %0d: got %h expected 000", c, {wide_p_valid_o, narrow_p_valid_o}); end
      if (c == 1 || c == 2) begin
        checks++;
        if (wide_q_ready_o !== ((c == 1) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rif_post_grant cycle %0d: got %b expected %b", c, wide_q_ready_o, (c == 1) ? 2'b01 : 2'b10);
        end
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    mode_i = 1'b0;
    pl_en  = 1'b0;
    pl_bank = 0;
    pl_addr = '0;
    pl_data = '0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_wide_alternate();
    test_fair_starve();
    test_wide_write_read();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
